// File: rtl/ex_forward_ctrl_pkg.sv
// Shared constants and stage-field type for the EX forwarding controller.
package ex_forward_ctrl_pkg;

    // Default architectural register-address width (32 registers).
    localparam int REG_AW = 5;

    // Operand mux select encoding; 2'b11 is never produced.
    localparam logic [1:0] FWD_RF  = 2'b00;  // value read in ID, carried in ID/EX
    localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB write-back value
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

    // Per-stage destination/control fields. Width tracks the package REG_AW,
    // so the top-level REG_AW must stay at this default.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_t;

endpackage

// File: rtl/ex_forward_ctrl_if.sv
// ID-side inputs and EX/WB-side outputs of the forwarding controller.
interface ex_forward_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic [REG_AW-1:0] wb_rd_o;
    logic              wb_regwrite_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    // Decoder / pipeline side
    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        input  fwd_a_o, fwd_b_o, stall_o, wb_rd_o, wb_regwrite_o, stall_cnt_o
    );

    // Controller side
    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
        output fwd_a_o, fwd_b_o, stall_o, wb_rd_o, wb_regwrite_o, stall_cnt_o
    );
endinterface

// File: rtl/ex_forward_ctrl_fwd_sel.sv
// Pure comparator: picks the forwarding source for one EX operand.
module ex_forward_ctrl_fwd_sel
    import ex_forward_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] exmem_rd_i,
    input  logic          exmem_we_i,
    input  logic [AW-1:0] memwb_rd_i,
    input  logic          memwb_we_i,
    output logic [1:0]    sel_o
);

    // Nearest producer wins; r0 is hardwired zero and never forwarded.
    always_comb begin
        sel_o = FWD_RF;
        if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i))
            sel_o = FWD_MEM;
        else if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i))
            sel_o = FWD_WB;
    end

endmodule

// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding selects, load-use stall and write-back address tracking.
module ex_forward_ctrl
    import ex_forward_ctrl_pkg::*;
#(
    parameter int REG_AW = ex_forward_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ex_forward_ctrl_if.slave bus
);

    logic [REG_AW-1:0] idex_rs_q, idex_rs_d;
    logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
    stage_t            idex_q, idex_d;
    stage_t            exmem_q, exmem_d;
    stage_t            memwb_q, memwb_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              stall;
    logic              bubble;

    // Load in ID/EX whose result the ID instruction needs next cycle.
    always_comb begin
        stall = bus.id_valid_i && idex_q.memread && (idex_q.rd != '0) &&
                ((idex_q.rd == bus.id_rs_i) || (idex_q.rd == bus.id_rt_i));
    end

    // Next-state for the stage shadows and the saturating stall counter.
    always_comb begin
        bubble    = stall || bus.flush_i || !bus.id_valid_i;
        idex_rs_d = bubble ? '0 : bus.id_rs_i;
        idex_rt_d = bubble ? '0 : bus.id_rt_i;
        idex_d    = '0;
        if (!bubble) begin
            idex_d.rd       = bus.id_rd_i;
            idex_d.regwrite = bus.id_regwrite_i;
            idex_d.memread  = bus.id_memread_i;
        end
        // memread is only needed for the load-use check in ID/EX.
        exmem_d          = idex_q;
        exmem_d.memread  = 1'b0;
        memwb_d          = exmem_q;
        stall_cnt_d      = stall_cnt_q;
        if (stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Stage registers advance every edge; reset discards all in-flight fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_rs_q   <= '0;
            idex_rt_q   <= '0;
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            idex_rs_q   <= idex_rs_d;
            idex_rt_q   <= idex_rt_d;
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    ex_forward_ctrl_fwd_sel #(.AW(REG_AW)) u_sel_a (
        .src_i      (idex_rs_q),
        .exmem_rd_i (exmem_q.rd),
        .exmem_we_i (exmem_q.regwrite),
        .memwb_rd_i (memwb_q.rd),
        .memwb_we_i (memwb_q.regwrite),
        .sel_o      (bus.fwd_a_o)
    );

    ex_forward_ctrl_fwd_sel #(.AW(REG_AW)) u_sel_b (
        .src_i      (idex_rt_q),
        .exmem_rd_i (exmem_q.rd),
        .exmem_we_i (exmem_q.regwrite),
        .memwb_rd_i (memwb_q.rd),
        .memwb_we_i (memwb_q.regwrite),
        .sel_o      (bus.fwd_b_o)
    );

    assign bus.stall_o       = stall;
    assign bus.wb_rd_o       = memwb_q.rd;
    assign bus.wb_regwrite_o = memwb_q.regwrite;
    assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Self-checking bench: instruction-history model plus directed literal checks.
module tb_ex_forward_ctrl;

    localparam int AW = 5;
    localparam int CW = 8;  // narrow counter so saturation is reachable quickly
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ex_forward_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    ex_forward_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: the three most recent instructions that entered EX, newest first.
    typedef struct {
        int rs, rt, rd;
        bit we, mr;
    } instr_t;
    instr_t hist[3];
    int     m_cnt = 0;

    function automatic bit m_stall();
        return bus.id_valid_i && hist[0].mr && hist[0].rd != 0 &&
               (hist[0].rd == int'(bus.id_rs_i) || hist[0].rd == int'(bus.id_rt_i));
    endfunction

    // Distance to the nearest in-flight producer of src: 1 ahead -> 2, 2 ahead -> 1.
    function automatic int m_fwd(int src);
        for (int d = 1; d <= 2; d++)
            if (src != 0 && hist[d].we && hist[d].rd == src) return 3 - d;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 1'b0, 1'b0};
            m_cnt = 0;
        end else begin
            instr_t n;
            bit s;
            s = m_stall();
            n = '{0, 0, 0, 1'b0, 1'b0};
            if (bus.id_valid_i && !bus.flush_i && !s)
                n = '{int'(bus.id_rs_i), int'(bus.id_rt_i), int'(bus.id_rd_i),
                      bus.id_regwrite_i, bus.id_memread_i};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = n;
            if (s && m_cnt < CMAX) m_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: outputs must match the model.
    always @(negedge clk) begin
        chk("fwd_a", int'(bus.fwd_a_o), m_fwd(hist[0].rs));
        chk("fwd_b", int'(bus.fwd_b_o), m_fwd(hist[0].rt));
        chk("stall", int'(bus.stall_o), int'(m_stall()));
        chk("wb_rd", int'(bus.wb_rd_o), hist[2].rd);
        chk("wb_we", int'(bus.wb_regwrite_o), int'(hist[2].we));
        chk("stall_cnt", int'(bus.stall_cnt_o), m_cnt);
    end

    task automatic drive(input bit v, input int rs, input int rt, input int rd,
                         input bit we, input bit mr, input bit fl);
        bus.id_valid_i    = v;
        bus.id_rs_i       = AW'(rs);
        bus.id_rt_i       = AW'(rt);
        bus.id_rd_i       = AW'(rd);
        bus.id_regwrite_i = we;
        bus.id_memread_i  = mr;
        bus.flush_i       = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int rs, input int rt, input int rd, input bit we, input bit mr);
        drive(1'b1, rs, rt, rd, we, mr, 1'b0);
        step();
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        step();
        chk("rst_fwd_a", int'(bus.fwd_a_o), 0);
        chk("rst_cnt", int'(bus.stall_cnt_o), 0);
        rst = 1'b0;
        nop();

        // Back-to-back ALU and increasing distance
        issue(1, 2, 3, 1, 0);
        issue(3, 4, 5, 1, 0);
        chk("b2b_a", int'(bus.fwd_a_o), 2);
        chk("b2b_b", int'(bus.fwd_b_o), 0);
        nop(); nop(); nop();
        issue(1, 2, 3, 1, 0);
        nop();
        issue(3, 4, 5, 1, 0);
        chk("dist2_a", int'(bus.fwd_a_o), 1);
        nop(); nop(); nop();
        issue(1, 2, 3, 1, 0);
        nop(); nop();
        issue(3, 4, 5, 1, 0);
        chk("dist3_a", int'(bus.fwd_a_o), 0);
        nop(); nop(); nop();

        // Double match: EX/MEM has priority
        issue(1, 2, 3, 1, 0);
        issue(1, 2, 3, 1, 0);
        issue(3, 3, 6, 1, 0);
        chk("dbl_a", int'(bus.fwd_a_o), 2);
        chk("dbl_b", int'(bus.fwd_b_o), 2);
        nop(); nop(); nop();

        // Load-use
        do_reset();
        issue(0, 0, 2, 1, 1);
        drive(1'b1, 2, 2, 4, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall", int'(bus.stall_o), 1);
        step();
        chk("lu_stall_once", int'(bus.stall_o), 0);
        chk("lu_cnt", int'(bus.stall_cnt_o), 1);
        step();
        chk("lu_a", int'(bus.fwd_a_o), 1);
        chk("lu_b", int'(bus.fwd_b_o), 1);
        nop(); nop(); nop();

        // Register 0
        issue(0, 0, 0, 1, 0);
        issue(0, 0, 7, 1, 0);
        chk("r0_a", int'(bus.fwd_a_o), 0);
        chk("r0_b", int'(bus.fwd_b_o), 0);
        issue(0, 0, 0, 1, 1);
        drive(1'b1, 0, 0, 4, 1'b1, 1'b0, 1'b0);
        #1;
        chk("r0_stall", int'(bus.stall_o), 0);
        nop(); nop(); nop();

        // Flush squashes the producer; flush with stall still reports stall
        drive(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b1);
        step();
        issue(3, 3, 5, 1, 0);
        chk("flush_a", int'(bus.fwd_a_o), 0);
        issue(0, 0, 2, 1, 1);
        drive(1'b1, 2, 0, 4, 1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_stall", int'(bus.stall_o), 1);
        step();
        nop(); nop(); nop();

        // Randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 99) < 70,
                  $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 10);
            step();
        end
        rst = 1'b0;

        // Mid-stream reset with a live load-use pair
        issue(1, 2, 3, 1, 0);
        issue(0, 0, 2, 1, 1);
        drive(1'b1, 2, 3, 4, 1'b1, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_stall", int'(bus.stall_o), 0);
        chk("mrst_wb_we", int'(bus.wb_regwrite_o), 0);
        chk("mrst_wb_rd", int'(bus.wb_rd_o), 0);
        chk("mrst_cnt", int'(bus.stall_cnt_o), 0);
        chk("mrst_fwd_b", int'(bus.fwd_b_o), 0);
        step();
        rst = 1'b0;
        issue(2, 3, 4, 1, 0);
        chk("post_rst_a", int'(bus.fwd_a_o), 0);
        chk("post_rst_b", int'(bus.fwd_b_o), 0);

        // Counter saturation: a self-dependent load stalls every other cycle
        do_reset();
        drive(1'b1, 2, 0, 2, 1'b1, 1'b1, 1'b0);
        repeat (2 * CMAX + 40) step();
        chk("cnt_sat", int'(bus.stall_cnt_o), CMAX);
        nop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
